// File: rtl/int_ctrl_pkg.sv
// Shared constants, state encoding and priority helper for the interrupt controller.
package int_ctrl_pkg;

    localparam int unsigned NUM_IRQ = 8;

    localparam logic [1:0] ADDR_IE   = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int unsigned EOI_BIT = 0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } state_e;

    // Index of the lowest set bit; bit 0 is the highest priority.
    function automatic logic [2:0] lowest_set(input logic [NUM_IRQ-1:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_ctrl_irq_sync.sv
// Multi-flop synchroniser for one asynchronous request line, with a rising-edge pulse
// derived from the synchronised value.
module int_ctrl_irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises 8 maskable lines plus NMI, prioritises them and
// hands one request at a time to the core, holding it in service until EOI.
module int_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_irq,
    input  logic        i_nmi_in,
    input  logic        i_sel,
    input  logic        i_wr,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_int,
    output logic [2:0]  o_int_num,
    output logic        o_nmi,
    input  logic        i_ack
);
    import int_ctrl_pkg::*;

    logic [NUM_IRQ:0]   w_async;
    logic [NUM_IRQ:0]   w_level;
    logic [NUM_IRQ:0]   w_rise;
    logic [NUM_IRQ-1:0] r_ie;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] w_pend_d;
    logic [NUM_IRQ-1:0] w_eff;
    logic [NUM_IRQ-1:0] w_cand;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_ack_clr;
    logic [2:0]         w_winner;
    logic [2:0]         r_int_num;
    logic [2:0]         w_int_num_d;
    logic [2:0]         r_isr_num;
    logic               w_any;
    logic               w_reg_wr;
    logic               w_eoi;
    logic               w_take;
    logic               r_int;
    logic               w_int_d;
    logic               r_nmi;
    logic               r_nmi_edge;
    logic               w_unused_wdata;
    state_e             r_state;
    state_e             w_state_d;

    assign w_async = {i_nmi_in, i_irq};

    for (genvar g = 0; g <= NUM_IRQ; g++) begin : g_sync
        int_ctrl_irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_async(w_async[g]),
            .o_level(w_level[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_eff          = r_pend | (w_level[NUM_IRQ-1:0] & ~r_mode);
    assign w_cand         = w_eff & r_ie;
    assign w_any          = |w_cand;
    assign w_winner       = lowest_set(w_cand);
    assign w_reg_wr       = i_sel & i_wr;
    assign w_eoi          = w_reg_wr && (i_addr == ADDR_STAT) && i_wdata[EOI_BIT];
    assign w_take         = (r_state == StReq) && w_any && i_ack && !r_nmi;
    assign w_w1c          = (w_reg_wr && (i_addr == ADDR_PEND)) ? i_wdata[NUM_IRQ-1:0] : '0;
    assign w_unused_wdata = ^i_wdata[31:NUM_IRQ];

    always_comb begin
        w_ack_clr = '0;
        if (w_take) w_ack_clr[r_int_num] = r_mode[r_int_num];
    end

    // New edges are ORed in last so a set beats a same-cycle clear.
    assign w_pend_d = (r_pend & ~w_w1c & ~w_ack_clr) | (w_rise[NUM_IRQ-1:0] & r_mode);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:    if (w_any) w_state_d = StReq;
            StReq: begin
                if (!w_any)                 w_state_d = StIdle;
                else if (i_ack && !r_nmi)   w_state_d = StService;
            end
            StService: if (w_eoi) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    // Next values for the registered core-facing request; int_num follows the winner in REQ.
    always_comb begin
        w_int_d     = 1'b0;
        w_int_num_d = r_int_num;
        case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_int_d     = 1'b1;
                    w_int_num_d = w_winner;
                end
            end
            StReq: begin
                if (w_any && !(i_ack && !r_nmi)) begin
                    w_int_d     = 1'b1;
                    w_int_num_d = w_winner;
                end
            end
            default: w_int_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ie       <= '0;
            r_mode     <= '0;
            r_pend     <= '0;
            r_int      <= 1'b0;
            r_int_num  <= '0;
            r_isr_num  <= '0;
            r_nmi      <= 1'b0;
            r_nmi_edge <= 1'b0;
        end else begin
            if (w_reg_wr && (i_addr == ADDR_IE))   r_ie   <= i_wdata[NUM_IRQ-1:0];
            if (w_reg_wr && (i_addr == ADDR_MODE)) r_mode <= i_wdata[NUM_IRQ-1:0];
            r_pend    <= w_pend_d;
            r_int     <= w_int_d;
            r_int_num <= w_int_num_d;
            if (w_take)                                r_isr_num <= r_int_num;
            else if ((r_state == StService) && w_eoi) r_isr_num <= '0;
            // Extra stage keeps NMI latency equal to the maskable edge path.
            r_nmi_edge <= w_rise[NUM_IRQ];
            r_nmi      <= r_nmi_edge | (r_nmi & ~i_ack);
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_sel) begin
            case (i_addr)
                ADDR_IE:   o_rdata = {24'b0, r_ie};
                ADDR_MODE: o_rdata = {24'b0, r_mode};
                ADDR_PEND: o_rdata = {24'b0, w_eff};
                default:   o_rdata = {23'b0, r_nmi, 1'b0, r_isr_num, 3'b0,
                                      (r_state == StService)};
            endcase
        end
    end

    assign o_int     = r_int;
    assign o_int_num = r_int_num;
    assign o_nmi     = r_nmi;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a delay-line reference model.
module tb_int_ctrl;

    localparam int S = 2;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq;
    logic        nmi_in;
    logic        sel;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        dut_int;
    logic [2:0]  dut_num;
    logic        dut_nmi;
    logic        ack;

    int n_checks = 0;
    int n_fail   = 0;

    int_ctrl #(
        .SYNC_STAGES(S)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_irq    (irq),
        .i_nmi_in (nmi_in),
        .i_sel    (sel),
        .i_wr     (wr),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_rdata  (rdata),
        .o_int    (dut_int),
        .o_int_num(dut_num),
        .o_nmi    (dut_nmi),
        .i_ack    (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw input history, pending/enable vectors, service bookkeeping.
    logic [8:0] hist [0:S+1];
    logic [7:0] m_ie, m_mode, m_pend;
    logic       m_int, m_svc, m_nmi;
    logic [2:0] m_num, m_isr;
    logic [8:0] t_lvl, t_rise, t_rise_old;
    logic [7:0] t_eff, t_cand, t_w1c, t_clr;
    logic       t_wr, t_eoi;
    int         t_win;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= S + 1; i++) hist[i] = '0;
            m_ie = 0; m_mode = 0; m_pend = 0;
            m_int = 0; m_svc = 0; m_nmi = 0; m_num = 0; m_isr = 0;
        end else begin
            t_lvl      = hist[S-1];
            t_rise     = hist[S-1] & ~hist[S];
            t_rise_old = hist[S] & ~hist[S+1];
            t_eff      = m_pend | (t_lvl[7:0] & ~m_mode);
            t_cand     = t_eff & m_ie;
            t_win      = 0;
            while (t_win < 7 && !t_cand[t_win]) t_win++;
            t_wr  = sel & wr;
            t_eoi = t_wr && addr == 2'd3 && wdata[0];
            t_w1c = (t_wr && addr == 2'd2) ? wdata[7:0] : 8'h00;
            t_clr = 8'h00;
            if (m_svc) begin
                if (t_eoi) begin
                    m_svc = 0;
                    m_isr = 0;
                end
            end else if (m_int) begin
                if (t_cand == 0) m_int = 0;
                else if (ack && !m_nmi) begin
                    m_svc = 1;
                    m_isr = m_num;
                    if (m_mode[m_num]) t_clr[m_num] = 1'b1;
                    m_int = 0;
                end else m_num = 3'(t_win);
            end else if (t_cand != 0) begin
                m_int = 1;
                m_num = 3'(t_win);
            end
            m_pend = (m_pend & ~t_w1c & ~t_clr) | (t_rise[7:0] & m_mode);
            m_nmi  = t_rise_old[8] | (m_nmi & ~ack);
            if (t_wr && addr == 2'd0) m_ie = wdata[7:0];
            if (t_wr && addr == 2'd1) m_mode = wdata[7:0];
            for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {nmi_in, irq};
        end
    end

    function automatic logic [31:0] model_rdata();
        logic [7:0] eff;
        logic [8:0] lvl;
        lvl = hist[S-1];
        eff = m_pend | (lvl[7:0] & ~m_mode);
        if (!sel) return 32'h0;
        case (addr)
            2'd0:    return {24'b0, m_ie};
            2'd1:    return {24'b0, m_mode};
            2'd2:    return {24'b0, eff};
            default: return {23'b0, m_nmi, 1'b0, m_isr, 3'b0, m_svc};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_int", 32'(dut_int), 32'(m_int));
        check("model_nmi", 32'(dut_nmi), 32'(m_nmi));
        check("model_rdata", rdata, model_rdata());
        if (m_int) check("model_int_num", 32'(dut_num), 32'(m_num));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        sel = 1; wr = 1; addr = a; wdata = d;
        tick();
        sel = 0; wr = 0; wdata = 0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        sel = 1; wr = 0; addr = a;
        @(negedge clk);
        check(name, rdata, exp);
        #1;
        sel = 0;
    endtask

    task automatic ack_pulse();
        ack = 1;
        tick();
        ack = 0;
    endtask

    initial begin
        rst_n = 0; irq = 0; nmi_in = 0; sel = 0; wr = 0; addr = 0; wdata = 0; ack = 0;
        repeat (2) @(negedge clk);
        check("reset_int", 32'(dut_int), 32'd0);
        check("reset_nmi", 32'(dut_nmi), 32'd0);
        #1 rst_n = 1;
        tick();
        rd_chk("reset_ie", 2'd0, 32'h0);
        rd_chk("reset_mode", 2'd1, 32'h0);
        rd_chk("reset_pend", 2'd2, 32'h0);
        rd_chk("reset_stat", 2'd3, 32'h0);

        // Two simultaneous edges: lowest index wins, the other stays pending.
        wr_reg(2'd0, 32'hFF);
        wr_reg(2'd1, 32'hFF);
        irq = 8'h24;
        repeat (3) @(negedge clk);
        check("edge_latency_low", 32'(dut_int), 32'd0);
        @(negedge clk);
        check("edge_int", 32'(dut_int), 32'd1);
        check("edge_num2", 32'(dut_num), 32'd2);
        #1 irq = 0;
        ack_pulse();
        check("ack_drops_int", 32'(dut_int), 32'd0);
        rd_chk("stat_after_ack", 2'd3, 32'h21);
        rd_chk("pend_after_ack", 2'd2, 32'h20);
        wr_reg(2'd3, 32'h1);
        @(negedge clk);
        check("eoi_int", 32'(dut_int), 32'd1);
        check("eoi_num5", 32'(dut_num), 32'd5);
        #1;
        ack_pulse();
        wr_reg(2'd3, 32'h1);

        // Level source withdrawn before ack.
        wr_reg(2'd0, 32'h08);
        wr_reg(2'd1, 32'h00);
        irq = 8'h08;
        repeat (4) @(negedge clk);
        check("level_num3", 32'(dut_num), 32'd3);
        check("level_int", 32'(dut_int), 32'd1);
        #1 irq = 0;
        repeat (4) @(negedge clk);
        check("level_drop_int", 32'(dut_int), 32'd0);
        #1;
        rd_chk("level_drop_pend", 2'd2, 32'h0);

        // Pre-emption in REQ by a higher-priority edge.
        wr_reg(2'd0, 32'hFF);
        wr_reg(2'd1, 32'hFF);
        irq = 8'h40;
        repeat (4) @(negedge clk);
        check("preempt_num6", 32'(dut_num), 32'd6);
        #1 irq = 8'h42;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("preempt_int_held", 32'(dut_int), 32'd1);
        end
        check("preempt_num1", 32'(dut_num), 32'd1);
        #1 irq = 0;
        ack_pulse();

        // NMI during service.
        nmi_in = 1;
        repeat (4) @(negedge clk);
        check("nmi_set", 32'(dut_nmi), 32'd1);
        #1 nmi_in = 0;
        ack_pulse();
        check("nmi_cleared", 32'(dut_nmi), 32'd0);
        rd_chk("stat_svc_kept", 2'd3, 32'h11);
        wr_reg(2'd3, 32'h1);
        @(negedge clk);
        check("pending6_int", 32'(dut_int), 32'd1);
        check("pending6_num", 32'(dut_num), 32'd6);
        #1;
        ack_pulse();
        wr_reg(2'd3, 32'h1);

        // Ack-clear of irq[4] coinciding with a fresh edge on irq[4].
        irq = 8'h10;
        repeat (4) @(negedge clk);
        check("race_num4", 32'(dut_num), 32'd4);
        #1 irq = 0;
        repeat (3) tick();
        irq = 8'h10;
        tick();
        tick();
        ack_pulse();
        rd_chk("race_pend_kept", 2'd2, 32'h10);
        rd_chk("race_stat", 2'd3, 32'h41);
        nmi_in = 1;
        repeat (4) @(negedge clk);
        check("pre_reset_nmi", 32'(dut_nmi), 32'd1);
        #1 irq = 0; nmi_in = 0;
        sel = 1; addr = 2'd0;
        rst_n = 0;
        #1;
        check("async_reset_nmi", 32'(dut_nmi), 32'd0);
        check("async_reset_int", 32'(dut_int), 32'd0);
        check("async_reset_ie", rdata, 32'h0);
        sel = 0;
        tick();
        rst_n = 1;
        tick();

        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                rst_n = 0;
                #2 rst_n = 1;
            end
            if ($urandom_range(0, 5) == 0) begin
                int k;
                k = int'($urandom_range(0, 7));
                irq[k] = ~irq[k];
            end
            if ($urandom_range(0, 40) == 0) nmi_in = ~nmi_in;
            ack   = ($urandom_range(0, 3) == 0);
            sel   = ($urandom_range(0, 2) == 0);
            wr    = sel && ($urandom_range(0, 2) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            tick();
        end
        sel = 0; wr = 0; ack = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
